// File: rtl/divide_result_collector_if.sv
// ============================================================================
//  Module      : divide_result_collector_if
//  Description : Handshake and status bundle between the divider-side
//                producer/consumer and the divide result collector.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface divide_result_collector_if #(
    parameter int QW    = 16,
    parameter int DVW   = 16,
    parameter int DEPTH = 8
);
    // Issue side
    logic                             go_in;
    logic [DVW-1:0]                   dv_in;
    logic [QW-1:0]                    quotient_in;
    logic                             issue_ok;

    // Result side
    logic [QW-1:0]                    q_out;
    logic                             q_dz;
    logic                             q_valid;
    logic                             q_ready;

    // Status
    logic [$clog2(DEPTH+1)-1:0]       fifo_count;
    logic                             err_issue;
    logic                             err_ovf;

    // Environment: issues operations, supplies quotients, consumes results
    modport master (
        output go_in, dv_in, quotient_in, q_ready,
        input  issue_ok, q_out, q_dz, q_valid, fifo_count, err_issue, err_ovf
    );

    // Collector
    modport slave (
        input  go_in, dv_in, quotient_in, q_ready,
        output issue_ok, q_out, q_dz, q_valid, fifo_count, err_issue, err_ovf
    );
endinterface

`default_nettype wire

// File: rtl/divide_result_collector.sv
// ============================================================================
//  Module      : divide_result_collector
//  Description : Tracks operations issued into a fixed-latency, non-stalling
//                divider pipeline, captures each quotient on arrival into a
//                circular FIFO with valid/ready output, and grants issue
//                credits so the FIFO cannot be overrun under legal use.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divide_result_collector #(
    parameter int PIPE_LAT = 52,
    parameter int QW       = 16,
    parameter int DVW      = 16,
    parameter int DEPTH    = 8
) (
    input  wire logic                  reloj,
    input  wire logic                  reset,
    divide_result_collector_if.slave   bus
);

    localparam int IW = $clog2(PIPE_LAT + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Tracking shift register: one {valid, dz} pair per pipeline stage
    logic [PIPE_LAT-1:0] r_vld_sr;
    logic [PIPE_LAT-1:0] r_dz_sr;

    logic [IW-1:0]       r_inflight;
    logic [CW-1:0]       r_count;
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [QW-1:0]       r_mem_q  [DEPTH];
    logic                r_mem_dz [DEPTH];
    logic [QW-1:0]       r_q_out;
    logic                r_q_dz;
    logic                r_err_issue;
    logic                r_err_ovf;

    logic                w_go;
    logic                w_go_dz;
    logic                w_arrive;
    logic                w_arrive_dz;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic                w_issue_ok;
    logic [PW-1:0]       w_wr_next;
    logic [PW-1:0]       w_rd_next;

    // Operations presented while in reset are never tracked
    assign w_go        = bus.go_in && !reset;
    assign w_go_dz     = w_go && (bus.dv_in == '0);
    assign w_arrive    = r_vld_sr[PIPE_LAT-1];
    assign w_arrive_dz = r_dz_sr[PIPE_LAT-1];

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_pop       = (r_count != '0) && bus.q_ready;
    // A full FIFO still accepts an arrival when the head leaves in the same cycle
    assign w_push      = w_arrive && (!w_full || w_pop);
    assign w_drop      = w_arrive && w_full && !w_pop;

    // Credits come from registered state only, so a pop frees a slot one cycle later
    assign w_issue_ok  = (int'(r_inflight) + int'(r_count)) < DEPTH;

    assign w_wr_next   = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
    assign w_rd_next   = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

    generate
        if (PIPE_LAT > 1) begin : g_sr_multi
            // Shift issue markers down the pipeline, cleared on reset
            always_ff @(posedge reloj) begin
                if (reset) begin
                    r_vld_sr <= '0;
                    r_dz_sr  <= '0;
                end else begin
                    r_vld_sr <= {r_vld_sr[PIPE_LAT-2:0], w_go};
                    r_dz_sr  <= {r_dz_sr[PIPE_LAT-2:0], w_go_dz};
                end
            end
        end else begin : g_sr_single
            // Single-stage pipeline: the marker arrives one cycle after issue
            always_ff @(posedge reloj) begin
                if (reset) begin
                    r_vld_sr <= '0;
                    r_dz_sr  <= '0;
                end else begin
                    r_vld_sr <= w_go;
                    r_dz_sr  <= w_go_dz;
                end
            end
        end
    endgenerate

    // Count operations in flight: up on issue, down on arrival
    always_ff @(posedge reloj) begin
        if (reset) begin
            r_inflight <= '0;
        end else if (w_go && !w_arrive) begin
            r_inflight <= r_inflight + IW'(1);
        end else if (!w_go && w_arrive) begin
            r_inflight <= r_inflight - IW'(1);
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read
    always_ff @(posedge reloj) begin
        if (w_push) begin
            r_mem_q[r_wr_ptr]  <= bus.quotient_in;
            r_mem_dz[r_wr_ptr] <= w_arrive_dz;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge reloj) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_next;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Registered head: bypass an arrival into an emptying FIFO, otherwise
    // preload the next entry on pop so back-to-back pops have no bubble
    always_ff @(posedge reloj) begin
        if (reset) begin
            r_q_out <= '0;
            r_q_dz  <= 1'b0;
        end else if (w_push && ((r_count == '0) || (w_pop && r_count == CW'(1)))) begin
            r_q_out <= bus.quotient_in;
            r_q_dz  <= w_arrive_dz;
        end else if (w_pop && (r_count >= CW'(2))) begin
            r_q_out <= r_mem_q[w_rd_next];
            r_q_dz  <= r_mem_dz[w_rd_next];
        end
    end

    // Sticky protocol-violation and overflow flags
    always_ff @(posedge reloj) begin
        if (reset) begin
            r_err_issue <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            if (bus.go_in && !w_issue_ok) begin
                r_err_issue <= 1'b1;
            end
            if (w_drop) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

    assign bus.issue_ok   = w_issue_ok;
    assign bus.q_out      = r_q_out;
    assign bus.q_dz       = r_q_dz;
    assign bus.q_valid    = (r_count != '0);
    assign bus.fifo_count = r_count;
    assign bus.err_issue  = r_err_issue;
    assign bus.err_ovf    = r_err_ovf;

endmodule

`default_nettype wire

// File: doc/divide_result_collector.md
Name: divide_result_collector

Overview:
- Sits directly downstream of the pipelined 32/16 divider.
- Tracks every operation issued into the divider and captures the quotient when it emerges after the fixed pipeline latency.
- Buffers results in a FIFO with a valid/ready output handshake.
- The divider pipeline cannot stall, so the block also grants issue credits upstream; the FIFO can therefore never be overrun under legal use.

Parameters:
- PIPE_LAT, 52: cycles from go sampled at the divider input to the matching quotient at the divider output.
- QW, 16: quotient width.
- DVW, 16: divisor width.
- DEPTH, 8: FIFO entries; must be ≥ 1.

Ports:
- reloj, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- go_in, input, 1: operation issued to the divider this cycle (same signal driving the divider go).
- dv_in, input, DVW: divisor issued with go_in; used only for the divide-by-zero flag.
- quotient_in, input, QW: divider quotient output.
- issue_ok, output, 1: upstream may assert go_in this cycle.
- q_out, output, QW: FIFO head quotient.
- q_dz, output, 1: FIFO head was a divide-by-zero operation.
- q_valid, output, 1: FIFO non-empty.
- q_ready, input, 1: consumer accepts the head.
- fifo_count, output, clog2(DEPTH+1): entries currently stored.
- err_issue, output, 1: sticky; go_in was seen while issue_ok=0.
- err_ovf, output, 1: sticky; a result arrived with the FIFO full and was dropped.

Behaviour:
- Reset (reloj edge with reset=1):
  - Tracking shift register cleared.
  - inflight=0, FIFO emptied, fifo_count=0.
  - q_valid=0, q_out=0, q_dz=0.
  - err_issue=0, err_ovf=0.
  - issue_ok=1 in the first cycle after reset.
  - go_in is ignored while reset=1.
  - Operations issued before or during reset are discarded; their quotients never enter the FIFO.
- Tracking:
  - PIPE_LAT-stage shift register of {valid, dz}.
  - Stage 0 loads {go_in, go_in && (dv_in==0)}.
  - An operation issued at cycle N has its arrival marked at cycle N+PIPE_LAT. In that cycle quotient_in is sampled and pushed with its dz bit.
- Inflight counter, width clog2(PIPE_LAT+1):
  - +1 on go_in.
  - −1 on arrival.
  - Unchanged when both occur in the same cycle.
- Credit:
  - issue_ok = (inflight + fifo_count) < DEPTH, combinational from registered state.
  - A pop in the current cycle does not add credit until the next cycle.
- go_in while issue_ok=0:
  - The operation is still tracked.
  - err_issue sets and stays set until reset.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo DEPTH.
  - Push on arrival; pop when q_valid && q_ready.
  - Simultaneous push and pop in the same cycle: both happen, fifo_count unchanged; this is legal even when full.
  - Push with the FIFO full and no pop: the result is dropped, err_ovf sets (sticky), and existing contents are unchanged.
  - Pop when empty: ignored.
  - q_out/q_dz show the head, read from registers; there is no bubble between back-to-back pops.
  - q_out/q_dz are held while q_valid && !q_ready.
- Outputs:
  - q_valid = (fifo_count != 0).
  - When empty, q_out/q_dz hold their last value; the consumer must not rely on it.
- Latency: a result is visible on q_valid at cycle N+PIPE_LAT+1 for go at N, with an empty FIFO.
- Divide by zero: quotient_in is passed through unchanged; q_dz=1 marks the entry.

Test Plan:
- Single op: reset, go_in=1 at cycle 0 with dv_in=7, quotient_in=0x008E at cycle 52, q_ready=1 -> q_valid=1 with q_out=0x008E, q_dz=0 at cycle 53 only; fifo_count returns to 0.
- Credit limit: q_ready=0, issue go whenever issue_ok=1 -> exactly 8 go cycles accepted, issue_ok=0 afterwards. Results 1..8 arrive, fifo_count=8, err_ovf=0, err_issue=0. Then q_ready=1 -> q_out reads 1..8 in order on consecutive cycles; issue_ok rises the cycle after the first pop.
- Divide by zero: go with dv_in=0, quotient_in=0xFFFF at arrival -> q_dz=1, q_out=0xFFFF. The next op with dv_in=3 -> q_dz=0.
- Overflow: q_ready=0, force 9 go pulses ignoring issue_ok -> err_issue=1 at the 9th go. At the 9th arrival, err_ovf=1, fifo_count stays 8, and the head is still result 1.
- Simultaneous and wrap: DEPTH=8, continuous go with q_ready=1 for 40 results -> fifo_count ≤1, all 40 quotients are output in order, and pointers wrap at least 4 times without loss.
- Reset mid-operation: issue 3 ops, assert reset for 1 cycle at cycle 20 -> no q_valid at cycles 52–54, inflight=0, issue_ok=1, errors cleared. An op issued at cycle 25 appears at cycle 78.
